alu_sched: RTL
==============

# alu_sched

Two-requester scheduler that shares the 8-bit ALU datapath (`main`) between two clients. It accepts operation requests over valid/ready handshakes and arbitrates between them round-robin. It drives the ALU's `on`/`in_sel`/`num1`/`num2`/`out_sel` inputs through a load/persist sequence, captures `out` after a fixed latency, and returns the result to the winning requester. It sits directly above the ALU and is the only agent driving the ALU's control inputs.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width
- `OP_W`, 7, width of one-hot operation select (`out_sel`)
- `ALU_LAT`, 1, cycles from load to valid `out`; legal range 1..15

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  2  per-requester request valid
- `req_ready`  out  2  per-requester accept; at most one bit high
- `req_a`  in  2*WIDTH  operand A; requester i at `[i*WIDTH +: WIDTH]`
- `req_b`  in  2*WIDTH  operand B, same packing
- `req_op`  in  2*OP_W  one-hot op select, same packing
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response accept
- `rsp_id`  out  1  requester the response belongs to
- `rsp_data`  out  WIDTH  ALU result
- `rsp_err`  out  1  op was not one-hot; `rsp_data`=0
- `alu_on`  out  1  ALU enable
- `alu_in_sel`  out  3  `{persist, load, reset}`
- `alu_num1`, `alu_num2`  out  WIDTH  ALU operands
- `alu_out_sel`  out  OP_W  ALU op select
- `alu_result`  in  WIDTH  ALU `out`
- `busy`  out  1  high whenever state != IDLE

## Operation
- States: CLR, IDLE, ISSUE, WAIT, RESP.
- CLR: entered on `rst`. Drives `alu_on`=1 and `alu_in_sel`=3'b001. Goes to IDLE next cycle.
- IDLE: `alu_on`=0, `alu_in_sel`=3'b100.
  - Grant is computed combinationally. If exactly one `req_valid` is high, that requester wins. If both are high, the requester not equal to `last_grant` wins.
  - `req_ready[g]` is high only in IDLE, only for the granted requester, and only while its `req_valid` is high.
  - On handshake, latch a/b/op/id and go to ISSUE.
- ISSUE (1 cycle):
  - If the latched op is one-hot, drive `alu_on`=1, `alu_in_sel`=3'b010, and present the latched operands/op on `alu_num1`/`alu_num2`/`alu_out_sel`. Load counter=`ALU_LAT`, then go to WAIT.
  - If the op is not one-hot (zero or ≥2 bits set), the ALU is not loaded (`alu_on`=0). Set `rsp_err`=1, `rsp_data`=0, and go to RESP.
- WAIT: `alu_on`=1, `alu_in_sel`=3'b100, operands held. The counter decrements each cycle. In the cycle where the counter equals 1, capture `alu_result` into `rsp_data` (`rsp_err`=0) and go to RESP.
- RESP: `rsp_valid`=1. `rsp_id`/`rsp_data`/`rsp_err` are stable until `rsp_ready`. On handshake, set `last_grant`=`rsp_id` and go to IDLE. `rsp_valid` is never dropped without a handshake.
- `alu_num1`/`alu_num2`/`alu_out_sel` are 0 in CLR/IDLE.
- Reset mid-operation discards the in-flight request without a response. `rsp_valid` is 0 in the cycle after `rst` is sampled.

## Timing
- Reset values, in the cycle after `rst` is sampled high:
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0
  - `alu_on`=1, `alu_in_sel`=3'b001, `alu_num1`/`alu_num2`/`alu_out_sel`=0
  - `busy`=1, `last_grant`=1, so requester 0 wins the first tie
- All outputs except `req_ready` are registered/Moore.
- Cycle counts are relative to the handshake at cycle 0 (IDLE):
  - ISSUE occurs in cycle 1.
  - WAIT occupies cycles 2..`ALU_LAT`+1.
  - `rsp_valid` rises in cycle `ALU_LAT`+2 (cycle 3 for the default).
  - For a non-one-hot op, `rsp_valid` rises in cycle 2.
- Throughput with `rsp_ready` tied high is one op per `ALU_LAT`+3 cycles.
- No path from `rsp_ready` to `req_ready`. A new request cannot be accepted in the same cycle as a response handshake; it is accepted in the following IDLE cycle.

## Structure
- Shared package `alu_pkg`:
  - `IN_RESET`=3'b001, `IN_LOAD`=3'b010, `IN_PERSIST`=3'b100
  - state encoding (3-bit)
  - one-hot check function
- Sub-module `rr_arb2`: inputs `req[1:0]`, `last`; output one-hot `gnt[1:0]`; purely combinational.
- The bench provides a behavioural ALU model with configurable latency (add on op bit 3, xor on bit 1).

## Test plan
- Reset, then idle 3 cycles: CLR for exactly one cycle (`alu_in_sel`=001), then IDLE with `alu_in_sel`=100, `busy`=0, `req_ready`=0.
- Req0 only, a=8'h57, b=8'h1A, op=7'b0001000 (add), `rsp_ready`=1: `req_ready`=2'b01 at cycle 0, `alu_in_sel`=010 at cycle 1, `rsp_valid` at cycle 3 with `rsp_data`=8'h71, `rsp_id`=0.
- Both requesters held valid for 4 ops (req1: a=8'h00, b=8'h01, op=7'b0000010, xor): grants alternate 0,1,0,1; req1 responses carry `rsp_data`=8'h01.
- Op 7'b0000000 and op 7'b0001010 from req1: `alu_on` stays 0, `rsp_valid` at cycle 2 with `rsp_err`=1, `rsp_data`=0.
- `rsp_ready` held low 5 cycles: `rsp_valid`/`rsp_data` stable, `req_ready` stays 0 despite `req_valid`; the handshake releases to IDLE.
- `ALU_LAT`=3 build, plus `rst` asserted in WAIT: `rsp_valid` at cycle 5 normally; with the mid-op reset there is no response, CLR follows, and the next request is served normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU scheduler: ALU input-select codes,
// scheduler state encoding and the one-hot operation check.
package alu_pkg;

   // ALU in_sel encoding {persist, load, reset}
   localparam logic [2:0] IN_RESET   = 3'b001;
   localparam logic [2:0] IN_LOAD    = 3'b010;
   localparam logic [2:0] IN_PERSIST = 3'b100;

   // Scheduler state encoding
   localparam int unsigned ST_W = 3;
   localparam logic [ST_W-1:0] ST_CLR   = 3'd0;
   localparam logic [ST_W-1:0] ST_IDLE  = 3'd1;
   localparam logic [ST_W-1:0] ST_ISSUE = 3'd2;
   localparam logic [ST_W-1:0] ST_WAIT  = 3'd3;
   localparam logic [ST_W-1:0] ST_RESP  = 3'd4;

   // True when exactly one bit of v is set; narrower ops are zero-extended
   function automatic logic is_onehot(input logic [31:0] v);
      return ($countones(v) == 1);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   req  : request vector
//   last : index of the most recently served requester
//   gnt  : one-hot grant; on a tie the requester other than last wins
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_sched.sv
// Shares one ALU between two requesters. Accepts ops over valid/ready,
// arbitrates round-robin, drives the ALU through load/persist, captures the
// result after ALU_LAT cycles and returns it with the requester id.
//   clk, rst                        : clock, synchronous active-high reset
//   req_valid/req_ready             : per-requester request handshake
//   req_a/req_b/req_op              : packed operands / one-hot op per requester
//   rsp_valid/rsp_ready             : response handshake
//   rsp_id/rsp_data/rsp_err         : response payload
//   alu_on/alu_in_sel/alu_num1/2/alu_out_sel : ALU control (registered)
//   alu_result                      : ALU output
//   busy                            : high whenever not idle
module alu_sched
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned OP_W    = 7,
   parameter int unsigned ALU_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           req_valid,
   output logic [1:0]           req_ready,
   input  logic [2*WIDTH-1:0]   req_a,
   input  logic [2*WIDTH-1:0]   req_b,
   input  logic [2*OP_W-1:0]    req_op,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_id,
   output logic [WIDTH-1:0]     rsp_data,
   output logic                 rsp_err,
   output logic                 alu_on,
   output logic [2:0]           alu_in_sel,
   output logic [WIDTH-1:0]     alu_num1,
   output logic [WIDTH-1:0]     alu_num2,
   output logic [OP_W-1:0]      alu_out_sel,
   input  logic [WIDTH-1:0]     alu_result,
   output logic                 busy
);

   localparam int unsigned CNT_W = 4;

   logic [ST_W-1:0]  state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             id_q, id_d;
   logic             op_ok_q, op_ok_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             rsp_valid_d, rsp_id_d, rsp_err_d;
   logic [WIDTH-1:0] rsp_data_d;
   logic             alu_on_d;
   logic [2:0]       alu_in_sel_d;
   logic [WIDTH-1:0] alu_num1_d, alu_num2_d;
   logic [OP_W-1:0]  alu_out_sel_d;
   logic             busy_d;

   logic [1:0]       gnt;
   logic             hs_c;
   logic [WIDTH-1:0] sel_a_c, sel_b_c;
   logic [OP_W-1:0]  sel_op_c;

   rr_arb2 u_arb (
      .req  (req_valid),
      .last (last_grant_q),
      .gnt  (gnt)
   );

   // Request accept is the only combinational output
   assign req_ready = (state_q == ST_IDLE) ? (gnt & req_valid) : 2'b00;
   assign hs_c      = |req_ready;

   // Winner's payload
   assign sel_a_c  = gnt[1] ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
   assign sel_b_c  = gnt[1] ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
   assign sel_op_c = gnt[1] ? req_op[2*OP_W-1:OP_W]  : req_op[OP_W-1:0];

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_CLR;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         op_ok_q      <= 1'b0;
         cnt_q        <= '0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
         alu_on       <= 1'b1;
         alu_in_sel   <= IN_RESET;
         alu_num1     <= '0;
         alu_num2     <= '0;
         alu_out_sel  <= '0;
         busy         <= 1'b1;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         op_ok_q      <= op_ok_d;
         cnt_q        <= cnt_d;
         rsp_valid    <= rsp_valid_d;
         rsp_id       <= rsp_id_d;
         rsp_data     <= rsp_data_d;
         rsp_err      <= rsp_err_d;
         alu_on       <= alu_on_d;
         alu_in_sel   <= alu_in_sel_d;
         alu_num1     <= alu_num1_d;
         alu_num2     <= alu_num2_d;
         alu_out_sel  <= alu_out_sel_d;
         busy         <= busy_d;
      end
   end

   // Next state; outputs are computed for the state being entered
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      id_d          = id_q;
      op_ok_d       = op_ok_q;
      cnt_d         = cnt_q;
      rsp_valid_d   = rsp_valid;
      rsp_id_d      = rsp_id;
      rsp_data_d    = rsp_data;
      rsp_err_d     = rsp_err;
      alu_on_d      = alu_on;
      alu_in_sel_d  = alu_in_sel;
      alu_num1_d    = alu_num1;
      alu_num2_d    = alu_num2;
      alu_out_sel_d = alu_out_sel;

      case (state_q)
         ST_CLR: begin
            state_d       = ST_IDLE;
            alu_on_d      = 1'b0;
            alu_in_sel_d  = IN_PERSIST;
            alu_num1_d    = '0;
            alu_num2_d    = '0;
            alu_out_sel_d = '0;
         end

         ST_IDLE: begin
            if (hs_c) begin
               state_d = ST_ISSUE;
               id_d    = gnt[1];
               op_ok_d = is_onehot(32'(sel_op_c));
               // Load decision is made here so ISSUE drives it registered
               if (is_onehot(32'(sel_op_c))) begin
                  alu_on_d      = 1'b1;
                  alu_in_sel_d  = IN_LOAD;
                  alu_num1_d    = sel_a_c;
                  alu_num2_d    = sel_b_c;
                  alu_out_sel_d = sel_op_c;
               end
            end
         end

         ST_ISSUE: begin
            if (op_ok_q) begin
               state_d      = ST_WAIT;
               cnt_d        = CNT_W'(ALU_LAT);
               alu_on_d     = 1'b1;
               alu_in_sel_d = IN_PERSIST;
            end else begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
            end
         end

         ST_WAIT: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               rsp_data_d  = alu_result;
               rsp_err_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_RESP: begin
            if (rsp_ready) begin
               state_d       = ST_IDLE;
               rsp_valid_d   = 1'b0;
               last_grant_d  = rsp_id;
               alu_on_d      = 1'b0;
               alu_in_sel_d  = IN_PERSIST;
               alu_num1_d    = '0;
               alu_num2_d    = '0;
               alu_out_sel_d = '0;
            end
         end

         default: state_d = ST_CLR;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

endmodule
